// File: rtl/dmem_arbiter_if.sv
// Requester and data-memory signal bundle for dmem_arbiter.
// The slave modport is the arbiter's view; master is the environment (requesters + memory).
interface dmem_arbiter_if;
  logic        r0_req;
  logic        r0_we;
  logic [31:0] r0_addr;
  logic [31:0] r0_wdata;
  logic        r0_gnt;
  logic        r0_done;
  logic        r0_err;
  logic [31:0] r0_rdata;

  logic        r1_req;
  logic        r1_we;
  logic [31:0] r1_addr;
  logic [31:0] r1_wdata;
  logic        r1_gnt;
  logic        r1_done;
  logic        r1_err;
  logic [31:0] r1_rdata;

  logic [31:0] mem_address;
  logic [31:0] mem_writeData;
  logic        mem_memWrite;
  logic        mem_memRead;
  logic [31:0] mem_readData;

  modport slave (
    input  r0_req, r0_we, r0_addr, r0_wdata,
    output r0_gnt, r0_done, r0_err, r0_rdata,
    input  r1_req, r1_we, r1_addr, r1_wdata,
    output r1_gnt, r1_done, r1_err, r1_rdata,
    output mem_address, mem_writeData, mem_memWrite, mem_memRead,
    input  mem_readData
  );

  modport master (
    output r0_req, r0_we, r0_addr, r0_wdata,
    input  r0_gnt, r0_done, r0_err, r0_rdata,
    output r1_req, r1_we, r1_addr, r1_wdata,
    input  r1_gnt, r1_done, r1_err, r1_rdata,
    input  mem_address, mem_writeData, mem_memWrite, mem_memRead,
    output mem_readData
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and IDLE->ACCESS->RESP sequencer for the single-port data memory.
// Requester 0 is the core load/store path, requester 1 the debug/program-loader port.
module dmem_arbiter #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned IDX_W = 5
) (
  input  logic          clock,
  input  logic          reset,
  dmem_arbiter_if.slave bus,
  output logic          busy
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t           state, state_d;
  logic             last_grant, last_grant_d;
  logic             sel, sel_d;
  logic             err, err_d;
  logic [1:0]       gnt, gnt_d;
  logic [1:0]       done, done_d;
  logic [1:0]       err_out, err_out_d;
  logic [31:0]      mem_addr, mem_addr_d;
  logic [31:0]      mem_wdata, mem_wdata_d;
  logic             mem_wr, mem_wr_d;
  logic             mem_rd, mem_rd_d;
  logic [1:0][31:0] rdata, rdata_d;

  logic             win;
  logic             req_we;
  logic [31:0]      req_addr;
  logic [31:0]      req_wdata;
  logic             req_err;

  // Winner of an IDLE sample: on a tie the requester that did not go last
  always_comb begin
    win       = (bus.r0_req & bus.r1_req) ? ~last_grant : bus.r1_req;
    req_we    = win ? bus.r1_we    : bus.r0_we;
    req_addr  = win ? bus.r1_addr  : bus.r0_addr;
    req_wdata = win ? bus.r1_wdata : bus.r0_wdata;
    req_err   = (req_addr[1:0] != 2'b00) ||
                ({2'b00, req_addr[31:2]} >= 32'(DEPTH));
  end

  always_comb begin
    state_d      = state;
    last_grant_d = last_grant;
    sel_d        = sel;
    err_d        = err;
    gnt_d        = '0;
    done_d       = '0;
    err_out_d    = '0;
    mem_addr_d   = '0;
    mem_wdata_d  = '0;
    mem_wr_d     = 1'b0;
    mem_rd_d     = 1'b0;
    rdata_d      = rdata;
    unique case (state)
      IDLE: begin
        if (bus.r0_req | bus.r1_req) begin
          state_d     = ACCESS;
          sel_d       = win;
          err_d       = req_err;
          gnt_d[win]  = 1'b1;
          mem_addr_d  = 32'(req_addr[IDX_W+1:2]);
          mem_wdata_d = req_wdata;
          mem_wr_d    = req_we & ~req_err;
          mem_rd_d    = ~req_we & ~req_err;
        end
      end
      ACCESS: begin
        state_d        = RESP;
        last_grant_d   = sel;
        done_d[sel]    = 1'b1;
        err_out_d[sel] = err;
        if (mem_rd) begin
          rdata_d[sel] = bus.mem_readData;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      sel        <= 1'b0;
      err        <= 1'b0;
      gnt        <= '0;
      done       <= '0;
      err_out    <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wr     <= 1'b0;
      mem_rd     <= 1'b0;
      rdata      <= '0;
    end else begin
      state      <= state_d;
      last_grant <= last_grant_d;
      sel        <= sel_d;
      err        <= err_d;
      gnt        <= gnt_d;
      done       <= done_d;
      err_out    <= err_out_d;
      mem_addr   <= mem_addr_d;
      mem_wdata  <= mem_wdata_d;
      mem_wr     <= mem_wr_d;
      mem_rd     <= mem_rd_d;
      rdata      <= rdata_d;
    end
  end

  assign bus.r0_gnt   = gnt[0];
  assign bus.r1_gnt   = gnt[1];
  assign bus.r0_done  = done[0];
  assign bus.r1_done  = done[1];
  assign bus.r0_err   = err_out[0];
  assign bus.r1_err   = err_out[1];
  assign bus.r0_rdata = rdata[0];
  assign bus.r1_rdata = rdata[1];

  // A store caught by reset in ACCESS must never reach the memory
  assign bus.mem_memWrite  = mem_wr & ~reset;
  assign bus.mem_memRead   = mem_rd;
  assign bus.mem_address   = mem_addr;
  assign bus.mem_writeData = mem_wdata;
  assign busy              = (state != IDLE);
endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a transaction-level model predicts grants and
// completions, a negedge monitor compares them against what the DUT presents.
module tb_dmem_arbiter;
  localparam int unsigned DEPTH = 32;

  logic clock = 1'b0;
  logic reset;
  logic busy;

  dmem_arbiter_if bus();

  dmem_arbiter #(.DEPTH(DEPTH), .IDX_W(5)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          cyc;
    int          sel;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wr;
    logic        rd;
  } gnt_rec_t;

  typedef struct {
    int          cyc;
    int          sel;
    logic        err;
    logic [31:0] rd0;
    logic [31:0] rd1;
  } done_rec_t;

  gnt_rec_t    gq[$];
  done_rec_t   dq[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc;
  logic [31:0] env_mem [DEPTH];
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] ref_rd  [2];

  function automatic logic [31:0] init_word(int i);
    return 32'h5A5A_0000 ^ (32'(i) * 32'h9E37_79B9);
  endfunction

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Memory attached to the DUT: combinational read, write on the rising edge
  assign bus.mem_readData = bus.mem_memRead ? env_mem[bus.mem_address[4:0]] : 32'h0;
  initial begin
    for (int i = 0; i < int'(DEPTH); i++) env_mem[i] = init_word(i);
    forever begin
      @(posedge clock);
      if (bus.mem_memWrite) env_mem[bus.mem_address[4:0]] = bus.mem_writeData;
    end
  end

  // Reference model: one transaction every three cycles, round-robin on ties
  initial begin : model
    int          stage;
    int          last;
    int          m_sel;
    logic        m_we;
    logic        m_err;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    gnt_rec_t    g;
    done_rec_t   d;
    for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = init_word(i);
    stage = 0; last = 1; cyc = 0;
    ref_rd[0] = 32'h0; ref_rd[1] = 32'h0;
    forever begin
      @(posedge clock);
      cyc++;
      if (reset) begin
        stage = 0; last = 1;
        ref_rd[0] = 32'h0; ref_rd[1] = 32'h0;
        gq.delete(); dq.delete();
      end else if (stage == 1) begin
        if (!m_err && m_we)  ref_mem[m_addr / 4] = m_wdata;
        if (!m_err && !m_we) ref_rd[m_sel] = ref_mem[m_addr / 4];
        d.cyc = cyc; d.sel = m_sel; d.err = m_err;
        d.rd0 = ref_rd[0]; d.rd1 = ref_rd[1];
        dq.push_back(d);
        last  = m_sel;
        stage = 2;
      end else if (stage == 2) begin
        stage = 0;
      end else if (bus.r0_req || bus.r1_req) begin
        if (bus.r0_req && bus.r1_req) m_sel = (last == 0) ? 1 : 0;
        else                          m_sel = bus.r1_req ? 1 : 0;
        m_we    = (m_sel == 1) ? bus.r1_we    : bus.r0_we;
        m_addr  = (m_sel == 1) ? bus.r1_addr  : bus.r0_addr;
        m_wdata = (m_sel == 1) ? bus.r1_wdata : bus.r0_wdata;
        m_err   = (m_addr % 4 != 0) || (m_addr / 4 >= DEPTH);
        g.cyc = cyc; g.sel = m_sel;
        g.addr = (m_addr / 4) % 32; g.wdata = m_wdata;
        g.wr = m_we & ~m_err; g.rd = ~m_we & ~m_err;
        gq.push_back(g);
        stage = 1;
      end
    end
  end

  // Monitor: pops an expectation whenever the DUT shows a grant or a completion
  always @(negedge clock) begin : monitor
    gnt_rec_t  g;
    done_rec_t d;
    logic      g0, g1, d0, d1;
    if (!reset) begin
      g0 = bus.r0_gnt; g1 = bus.r1_gnt; d0 = bus.r0_done; d1 = bus.r1_done;
      check("gnt_exclusive", 32'(g0 & g1), 32'h0);
      check("done_exclusive", 32'(d0 & d1), 32'h0);
      check("busy", 32'(busy), 32'(g0 | g1 | d0 | d1));
      if (g0 | g1) begin
        if (gq.size() == 0) check("gnt_unexpected", 32'(1), 32'(0));
        else begin
          g = gq.pop_front();
          check("gnt_sel", 32'(g1), 32'(g.sel));
          check("gnt_cycle", 32'(cyc), 32'(g.cyc));
          check("mem_address", bus.mem_address, g.addr);
          check("mem_writeData", bus.mem_writeData, g.wdata);
          check("mem_memWrite", 32'(bus.mem_memWrite), 32'(g.wr));
          check("mem_memRead", 32'(bus.mem_memRead), 32'(g.rd));
        end
      end else begin
        check("mem_address_idle", bus.mem_address, 32'h0);
        check("mem_writeData_idle", bus.mem_writeData, 32'h0);
        check("mem_strobes_idle", 32'({bus.mem_memWrite, bus.mem_memRead}), 32'h0);
      end
      if (d0 | d1) begin
        if (dq.size() == 0) check("done_unexpected", 32'(1), 32'(0));
        else begin
          d = dq.pop_front();
          check("done_sel", 32'(d1), 32'(d.sel));
          check("done_cycle", 32'(cyc), 32'(d.cyc));
          check("done_err", 32'(d1 ? bus.r1_err : bus.r0_err), 32'(d.err));
          check("err_other", 32'(d1 ? bus.r0_err : bus.r1_err), 32'h0);
        end
      end else begin
        check("err_idle", 32'({bus.r0_err, bus.r1_err}), 32'h0);
      end
      check("r0_rdata", bus.r0_rdata, ref_rd[0]);
      check("r1_rdata", bus.r1_rdata, ref_rd[1]);
    end
  end

  task automatic set_port(input int p, input logic req, input logic we,
                          input logic [31:0] a, input logic [31:0] d);
    if (p == 0) begin
      bus.r0_req = req; bus.r0_we = we; bus.r0_addr = a; bus.r0_wdata = d;
    end else begin
      bus.r1_req = req; bus.r1_we = we; bus.r1_addr = a; bus.r1_wdata = d;
    end
  endtask

  // One request held until granted; abort=1 pulls reset during its ACCESS cycle
  task automatic txn(input int p, input logic we, input logic [31:0] a,
                     input logic [31:0] d, input bit abort);
    bit got = 0;
    @(posedge clock); #1;
    set_port(p, 1'b1, we, a, d);
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clock);
      if ((p == 0) ? bus.r0_gnt : bus.r1_gnt) got = 1;
    end
    check("gnt_within_bound", 32'(got), 32'(1));
    if (abort) begin
      #1 reset = 1'b1;
      #1 check("reset_gates_memWrite", 32'(bus.mem_memWrite), 32'h0);
      @(posedge clock); #1;
      reset = 1'b0;
      set_port(p, 1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clock);
      check("reset_abort_idle", 32'(busy), 32'h0);
      check("reset_no_done", 32'({bus.r0_done, bus.r1_done}), 32'h0);
    end else begin
      @(posedge clock); #1;
      set_port(p, 1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clock);
    end
  endtask

  task automatic apply_reset();
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    int          k;
    logic [31:0] a;
    k = int'($urandom_range(0, 9));
    a = 32'($urandom_range(0, 31)) << 2;
    if (k == 7)      a = a | 32'($urandom_range(1, 3));
    else if (k == 8) a = 32'($urandom_range(32, 40)) << 2;
    else if (k == 9) a = $urandom & 32'hFFFF_FFFC;
    return a;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got t=%0t expected < 100000", $time);
    $fatal(1);
  end

  initial begin : stim
    bit pend [2];
    reset = 1'b1;
    set_port(0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_port(1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_gnt", 32'({bus.r0_gnt, bus.r1_gnt, bus.r0_done, bus.r1_done}), 32'h0);
    check("reset_err", 32'({bus.r0_err, bus.r1_err}), 32'h0);
    check("reset_mem", 32'({bus.mem_memWrite, bus.mem_memRead}), 32'h0);
    check("reset_mem_address", bus.mem_address, 32'h0);
    check("reset_rdata", bus.r0_rdata | bus.r1_rdata, 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    @(posedge clock); #1 reset = 1'b0;

    // Store then load through requester 0
    txn(0, 1'b1, 32'h08, 32'hDEAD_BEEF, 1'b0);
    txn(0, 1'b0, 32'h08, 32'h0, 1'b0);
    check("r0_load_back", bus.r0_rdata, 32'hDEAD_BEEF);

    // Both requesting continuously from reset: r0 first, then alternating
    apply_reset();
    set_port(0, 1'b1, 1'b0, 32'h08, 32'h0);
    set_port(1, 1'b1, 1'b0, 32'h14, 32'h0);
    repeat (13) @(posedge clock);
    #1;
    set_port(0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_port(1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (4) @(posedge clock);

    // Top word succeeds, one past the end is rejected, word 0 untouched
    txn(1, 1'b1, 32'h7C, 32'hCAFE_F00D, 1'b0);
    txn(1, 1'b1, 32'h80, 32'h1111_2222, 1'b0);
    txn(1, 1'b0, 32'h00, 32'h0, 1'b0);
    check("word0_unchanged", bus.r1_rdata, init_word(0));

    // Misaligned load leaves r0_rdata alone
    txn(0, 1'b0, 32'h06, 32'h0, 1'b0);
    check("misaligned_holds_rdata", bus.r0_rdata, 32'hDEAD_BEEF);

    // Reset during the ACCESS of a store: the old data survives
    txn(0, 1'b1, 32'h10, 32'h1111_0000, 1'b0);
    txn(0, 1'b1, 32'h10, 32'hBADB_AD00, 1'b1);
    txn(0, 1'b0, 32'h10, 32'h0, 1'b0);
    check("aborted_store_not_committed", bus.r0_rdata, 32'h1111_0000);

    // r1 load leaves r0_rdata untouched
    txn(0, 1'b1, 32'h0C, 32'h0000_1234, 1'b0);
    txn(0, 1'b0, 32'h0C, 32'h0, 1'b0);
    txn(1, 1'b0, 32'h14, 32'h0, 1'b0);
    check("r0_rdata_kept", bus.r0_rdata, 32'h0000_1234);
    check("r1_word5", bus.r1_rdata, init_word(5));

    // Random traffic on both ports, each request held until granted
    pend[0] = 0; pend[1] = 0;
    for (int c = 0; c < 400; c++) begin
      @(posedge clock); #1;
      for (int p = 0; p < 2; p++) begin
        if ((p == 0) ? bus.r0_gnt : bus.r1_gnt) pend[p] = 0;
        if (!pend[p] && $urandom_range(0, 2) == 0) begin
          pend[p] = 1;
          set_port(p, 1'b1, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
        end else if (!pend[p]) begin
          set_port(p, 1'b0, 1'b0, 32'h0, 32'h0);
        end
      end
    end
    @(posedge clock); #1;
    set_port(0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_port(1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (6) @(posedge clock);
    @(negedge clock);
    check("gnt_queue_drained", 32'(gq.size()), 32'h0);
    check("done_queue_drained", 32'(dq.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-requester arbiter and access sequencer for the single-port data memory of the RISC-V datapath.
Requester 0 is the core load/store path; requester 1 is the debug/program-loader port.
Runs each accepted request as a fixed three-state transaction (IDLE -> ACCESS -> RESP) with round-robin fairness.
Converts byte addresses to word indices and rejects misaligned or out-of-range accesses before they reach memory.

Parameters:
DEPTH, 32, number of 32-bit words in the data memory; a word index must be below DEPTH.
IDX_W, 5, width of the word index; equals clog2(DEPTH).

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
r0_req  in  1  requester 0 request; held until r0_gnt
r0_we  in  1  requester 0 write enable (1=store, 0=load)
r0_addr  in  32  requester 0 byte address
r0_wdata  in  32  requester 0 store data
r0_gnt  out  1  one-cycle pulse: requester 0 request accepted
r0_done  out  1  one-cycle pulse: requester 0 transaction complete
r0_err  out  1  valid with r0_done: access rejected
r0_rdata  out  32  requester 0 load data, valid from r0_done
r1_req, r1_we, r1_addr, r1_wdata, r1_gnt, r1_done, r1_err, r1_rdata  same as r0_*, for requester 1
mem_address  out  32  word index to memory, zero-extended
mem_writeData  out  32  store data to memory
mem_memWrite  out  1  memory write strobe
mem_memRead  out  1  memory read enable
mem_readData  in  32  memory read data; combinational from mem_address/mem_memRead
busy  out  1  high whenever state != IDLE

Behaviour:
- States: IDLE, ACCESS, RESP. Encode as a registered FSM.
- Reset (sync): state=IDLE, last_grant=1 (requester 0 wins the first tie). All gnt/done/err/mem_* outputs = 0; r0_rdata = r1_rdata = 0; busy=0.
- IDLE: sample r0_req and r1_req at the clock edge.
  - One request -> that requester wins.
  - Both requests -> the requester != last_grant wins.
  - On a win: latch sel, we, addr, wdata, and err. err = (addr[1:0] != 0) or (addr[31:2] >= DEPTH). Go to ACCESS.
  - No request -> stay in IDLE.
- ACCESS (exactly 1 cycle):
  - Assert rN_gnt=1 for sel.
  - mem_address = {0, addr[IDX_W+1:2]}; mem_writeData = wdata.
  - mem_memWrite = we & ~err; mem_memRead = ~we & ~err.
  - At the closing edge: the memory commits the write. For a load, rN_rdata <= mem_readData. Set last_grant <= sel. Go to RESP.
- RESP (exactly 1 cycle): rN_done=1 and rN_err=err for sel; mem_* = 0. Then go to IDLE.
- Latency: request sampled at the end of cycle N -> gnt in N+1 -> done in N+2 -> IDLE in N+3. Maximum throughput is one transaction per 3 cycles.
- Outside ACCESS: mem_address, mem_writeData, mem_memWrite and mem_memRead are all 0.
- rN_rdata is updated only by a successful load of that requester. It holds through stores, errors and the other requester's traffic.
- Error access: no memWrite, no memRead, rdata unchanged, err=1 with done.
- Requesters may drop req after gnt. A req still high in a later IDLE cycle is a new request.
- The losing requester keeps req high and is served in the next IDLE; no starvation.
- gnt and done are never asserted for both requesters in the same cycle.
- Reset mid-transaction: the FSM aborts to IDLE on the same edge. No done is issued. A write in ACCESS during the reset cycle must not be committed: mem_memWrite is gated by ~reset.
- All outputs are registered or decoded from state registers only. There is no combinational path from rN_req to the mem_* outputs.

Test Plan:
- r0 store addr=0x08, wdata=0xDEADBEEF, then r0 load addr=0x08 -> mem_address=2 with memWrite=1 in ACCESS; the load returns r0_rdata=0xDEADBEEF with r0_done and r0_err=0; done 2 cycles after the sampled req.
- r0 and r1 both request loads continuously after reset -> grants alternate r0, r1, r0, r1. gnt pulses are spaced 3 cycles apart; never two gnts in one cycle.
- r1 store addr=0x7C (word 31, DEPTH=32) succeeds; r1 store addr=0x80 (word 32) -> r1_err=1, memWrite stays 0, and memory word 0 is unchanged on readback.
- r0 load addr=0x06 (misaligned) -> r0_err=1, memRead=0, and r0_rdata keeps its previous value.
- Assert reset during ACCESS of an r0 store to addr=0x10 -> no r0_done, FSM in IDLE, mem_memWrite=0 that cycle, and a later load of 0x10 returns the old data.
- r1 load of word 5 with r0 idle, while r0_rdata=0x1234 -> r1_rdata updates and r0_rdata stays 0x1234.
